branch_ctrl: RTL

//  Sequences branch resolution in the ID stage around the branch comparator.

---
 rtl/branch_ctrl_if.sv | 36 +++
 rtl/branch_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/branch_ctrl_if.sv
// Bus between the ID-stage branch controller and the surrounding pipeline.
// master = pipeline side, slave = branch_ctrl.
interface branch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic             id_valid;
    logic             id_is_branch;
    logic [2:0]       id_br_type;
    logic [31:0]      id_pc;
    logic [31:0]      id_target;
    logic             id_pred_taken;
    logic             opnd_ready;
    logic [1:0]       cmp_result;
    logic             cmp_zero_mode;
    logic             stall;
    logic             flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output if_pc, id_valid, id_is_branch, id_br_type, id_pc, id_target,
               id_pred_taken, opnd_ready, cmp_result,
        input  pred_taken, cmp_zero_mode, stall, flush, redirect_valid,
               redirect_pc, mispredict_cnt
    );

    modport slave (
        input  if_pc, id_valid, id_is_branch, id_br_type, id_pc, id_target,
               id_pred_taken, opnd_ready, cmp_result,
        output pred_taken, cmp_zero_mode, stall, flush, redirect_valid,
               redirect_pc, mispredict_cnt
    );
endinterface

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution: operand-wait stall, taken decode, 2-bit BHT
// prediction/update, one-cycle flush+redirect on mispredict, mispredict counter.
module branch_ctrl #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    branch_ctrl_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_bht [DEPTH];
    logic             r_flush;
    logic             r_redirect_valid;
    logic [31:0]      r_redirect_pc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_br;
    logic             w_active;
    logic             w_taken;
    logic             w_resolve;
    logic             w_mispredict;
    logic             w_eq, w_lt, w_gt;
    logic [IDX_W-1:0] w_ridx;
    logic [IDX_W-1:0] w_widx;
    logic [1:0]       w_ctr;
    logic             w_unused;

    assign w_br     = bus.id_valid & bus.id_is_branch & (bus.id_br_type <= 3'd5);
    assign w_active = (r_state != S_FLUSH);
    assign w_eq     = (bus.cmp_result == 2'b01);
    assign w_lt     = (bus.cmp_result == 2'b10);
    assign w_gt     = (bus.cmp_result == 2'b11);
    assign w_ridx   = bus.if_pc[IDX_W+1:2];
    assign w_widx   = bus.id_pc[IDX_W+1:2];
    assign w_ctr    = r_bht[w_widx];
    assign w_unused = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0]};

    // A comparator result of "none" never yields taken, even for BNE.
    always_comb begin
        w_taken = 1'b0;
        case (bus.id_br_type)
            3'd0:    w_taken = w_eq;
            3'd1:    w_taken = ~w_eq;
            3'd2:    w_taken = w_eq | w_lt;
            3'd3:    w_taken = w_gt;
            3'd4:    w_taken = w_lt;
            3'd5:    w_taken = w_eq | w_gt;
            default: w_taken = 1'b0;
        endcase
        if (bus.cmp_result == 2'b00)
            w_taken = 1'b0;
    end

    assign w_resolve    = w_active & w_br & bus.opnd_ready;
    assign w_mispredict = w_taken ^ bus.id_pred_taken;

    assign bus.stall          = w_active & w_br & ~bus.opnd_ready;
    assign bus.cmp_zero_mode  = (bus.id_br_type >= 3'd2);
    assign bus.pred_taken     = r_bht[w_ridx][1];
    assign bus.flush          = r_flush;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.mispredict_cnt = r_cnt;

    always_comb begin
        w_state_nxt = S_IDLE;
        if (!w_active)
            w_state_nxt = S_IDLE;
        else if (w_resolve)
            w_state_nxt = w_mispredict ? S_FLUSH : S_IDLE;
        else if (w_br)
            w_state_nxt = S_WAIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_cnt            <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                r_bht[i] <= 2'b01;
        end else begin
            r_state          <= w_state_nxt;
            r_flush          <= w_resolve & w_mispredict;
            r_redirect_valid <= w_resolve & w_mispredict;
            if (w_resolve) begin
                r_redirect_pc <= w_taken ? bus.id_target : bus.id_pc + 32'd4;
                if (w_taken && w_ctr != 2'b11)
                    r_bht[w_widx] <= w_ctr + 2'd1;
                else if (!w_taken && w_ctr != 2'b00)
                    r_bht[w_widx] <= w_ctr - 2'd1;
                if (w_mispredict && r_cnt != '1)
                    r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule
